// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: keypad code comparator with timed unlock, error and timeout handling.
// Define DOOR_LOCKOUT_EN to add the consecutive-failure counter and LOCKOUT state.
module door_lock_ctrl #(
  parameter int BTN_W    = 4,
  parameter int CODE_LEN = 4,
  parameter int TIMEOUT  = 10,
  parameter int OPEN_CYC = 8,
  parameter int ERR_CYC  = 4,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BTN_W-1:0]          btn,
  input  logic [CODE_LEN*BTN_W-1:0] code,
  output logic                      y,
  output logic                      green,
  output logic                      red,
  output logic                      locked
);

  localparam int MAX_A   = (TIMEOUT > OPEN_CYC) ? TIMEOUT : OPEN_CYC;
  localparam int MAX_B   = (ERR_CYC > LOCK_CYC) ? ERR_CYC : LOCK_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(ERR_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_LEN - 1);

`ifdef DOOR_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_OPEN, S_ERROR, S_LOCKOUT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_OPEN, S_ERROR} state_e;
`endif

  state_e             state_q, state_d;
  logic [BTN_W-1:0]   btn_q, btn_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mm_q, mm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef DOOR_LOCKOUT_EN
  logic [FAIL_W-1:0]  fail_q, fail_d;
`endif

  logic               acc;
  logic [BTN_W-1:0]   digit;
  logic               digit_bad;
  logic               mm_all;

  // A zero code digit is never matched, even though btn can't be 0 when acc is set.
  always_comb begin
    acc       = (btn != '0) && (btn != btn_q);
    digit     = code[idx_q*BTN_W +: BTN_W];
    digit_bad = (digit == '0) || (btn != digit);
    mm_all    = mm_q | digit_bad;
  end

  always_comb begin
    state_d = state_q;
    btn_d   = btn;
    idx_d   = idx_q;
    mm_d    = mm_q;
    cnt_d   = cnt_q;
`ifdef DOOR_LOCKOUT_EN
    fail_d  = fail_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (acc) begin
          cnt_d = '0;
          if (CODE_LEN == 1) begin
            state_d = digit_bad ? S_ERROR : S_OPEN;
            idx_d   = '0;
            mm_d    = 1'b0;
          end else begin
            state_d = S_ENTRY;
            idx_d   = IDX_W'(1);
            mm_d    = digit_bad;
          end
        end
      end

      S_ENTRY: begin
        if (acc) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = mm_all ? S_ERROR : S_OPEN;
            idx_d   = '0;
            mm_d    = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
            mm_d  = mm_all;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERROR;
          cnt_d   = '0;
          idx_d   = '0;
          mm_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_OPEN: begin
        if (cnt_q == OPEN_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ERROR: begin
        if (cnt_q == ERR_LAST) begin
          cnt_d   = '0;
`ifdef DOOR_LOCKOUT_EN
          state_d = (fail_q == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef DOOR_LOCKOUT_EN
      S_LOCKOUT: begin
        if (cnt_q == LOCK_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          fail_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        mm_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase

`ifdef DOOR_LOCKOUT_EN
    // Failure is counted once, on the transition into ERROR.
    if (state_d == S_ERROR && state_q != S_ERROR && fail_q != FAIL_MAX) begin
      fail_d = fail_q + 1'b1;
    end
    if (state_d == S_OPEN) begin
      fail_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      btn_q   <= '0;
      idx_q   <= '0;
      mm_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef DOOR_LOCKOUT_EN
      fail_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
      cnt_q   <= cnt_d;
`ifdef DOOR_LOCKOUT_EN
      fail_q  <= fail_d;
`endif
    end
  end

  always_comb begin
    y     = (state_q == S_OPEN);
    green = (state_q == S_OPEN);
`ifdef DOOR_LOCKOUT_EN
    red    = (state_q == S_ERROR) || (state_q == S_LOCKOUT);
    locked = (state_q == S_LOCKOUT);
`else
    red    = (state_q == S_ERROR);
    locked = 1'b0;
`endif
  end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Bench for door_lock_ctrl: sequence-level reference model compared every cycle,
// plus hand-computed window counts for the key timing cases.
module tb_door_lock_ctrl;

  localparam int BTN_W    = 4;
  localparam int CODE_LEN = 4;
  localparam int TIMEOUT  = 10;
  localparam int OPEN_CYC = 8;
  localparam int ERR_CYC  = 4;
  localparam int MAX_FAIL = 3;
  localparam int LOCK_CYC = 32;

`ifdef DOOR_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_ENTRY = 1;
  localparam int P_OPEN  = 2;
  localparam int P_ERR   = 3;
  localparam int P_LOCK  = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [BTN_W-1:0]          btn;
  logic [CODE_LEN*BTN_W-1:0] code_v;
  logic                      y, green, red, locked;

  door_lock_ctrl #(
    .BTN_W   (BTN_W),
    .CODE_LEN(CODE_LEN),
    .TIMEOUT (TIMEOUT),
    .OPEN_CYC(OPEN_CYC),
    .ERR_CYC (ERR_CYC),
    .MAX_FAIL(MAX_FAIL),
    .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .code  (code_v),
    .y     (y),
    .green (green),
    .red   (red),
    .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model: collects accepted digits, compares the whole sequence
  // at once and tracks dwell periods as absolute edge-count deadlines.
  int               m_phase = P_IDLE;
  int               m_until = 0;
  int               m_last  = 0;
  int               m_fails = 0;
  int               m_cyc   = 0;
  logic [BTN_W-1:0] m_prev  = '0;
  int               m_got[$];

  function automatic bit code_ok();
    logic [BTN_W-1:0] dg;
    for (int i = 0; i < CODE_LEN; i++) begin
      dg = code_v[i*BTN_W +: BTN_W];
      if (dg == '0 || int'(dg) != m_got[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = P_IDLE;
      m_got.delete();
      m_fails = 0;
      m_cyc   = 0;
      m_prev  = '0;
    end else begin
      m_cyc++;
      if (m_phase == P_IDLE || m_phase == P_ENTRY) begin
        if (btn != '0 && btn != m_prev) begin
          if (m_phase == P_IDLE) m_got.delete();
          m_got.push_back(int'(btn));
          m_last  = m_cyc;
          m_phase = P_ENTRY;
          if (m_got.size() == CODE_LEN) begin
            if (code_ok()) begin
              m_phase = P_OPEN;
              m_until = m_cyc + OPEN_CYC;
              m_fails = 0;
            end else begin
              m_phase = P_ERR;
              m_until = m_cyc + ERR_CYC;
              if (m_fails < MAX_FAIL) m_fails++;
            end
          end
        end else if (m_phase == P_ENTRY && m_cyc - m_last == TIMEOUT) begin
          m_phase = P_ERR;
          m_until = m_cyc + ERR_CYC;
          if (m_fails < MAX_FAIL) m_fails++;
        end
      end else if (m_cyc == m_until) begin
        if (m_phase == P_ERR && LOCK_EN && m_fails >= MAX_FAIL) begin
          m_phase = P_LOCK;
          m_until = m_cyc + LOCK_CYC;
        end else begin
          if (m_phase == P_LOCK) m_fails = 0;
          m_phase = P_IDLE;
        end
      end
      m_prev = btn;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  int w_idx, w_y, w_red, w_lock, w_first_y, w_first_red, w_first_lock;

  task automatic clear_win();
    w_idx = 0; w_y = 0; w_red = 0; w_lock = 0;
    w_first_y = -1; w_first_red = -1; w_first_lock = -1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d", name, got, exp);
  endtask

  // One cycle: compare against the model on the falling edge, then advance.
  task automatic tick();
    logic [3:0] exp_o;
    logic [3:0] got_o;
    @(negedge clk);
    exp_o = {m_phase == P_OPEN, m_phase == P_OPEN,
             m_phase == P_ERR || m_phase == P_LOCK, m_phase == P_LOCK};
    got_o = {y, green, red, locked};
    n_total++;
    if (got_o === exp_o) n_pass++;
    else $display("FAIL cycle_model t=%0t y,green,red,locked got %b expected %b",
                  $time, got_o, exp_o);
    if (y)      begin w_y++;    if (w_first_y    < 0) w_first_y    = w_idx; end
    if (red)    begin w_red++;  if (w_first_red  < 0) w_first_red  = w_idx; end
    if (locked) begin w_lock++; if (w_first_lock < 0) w_first_lock = w_idx; end
    w_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [BTN_W-1:0] b, input int n);
    btn = b;
    repeat (n) tick();
  endtask

  task automatic press(input logic [BTN_W-1:0] d);
    apply(d, 1);
    apply('0, 1);
  endtask

  // Window index 0 is the cycle right after the last digit is sampled.
  task automatic press_last(input logic [BTN_W-1:0] d);
    apply(d, 1);
    btn = '0;
    clear_win();
  endtask

  task automatic enter_good();
    press(4'd1); press(4'd3); press(4'd2); press_last(4'd4);
    repeat (12) tick();
  endtask

  task automatic enter_bad();
    press(4'd1); press(4'd2); press(4'd3); press_last(4'd4);
  endtask

  initial begin
    reset  = 1'b0;
    btn    = '0;
    code_v = 16'h4231;
    clear_win();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_outputs", int'({y, green, red, locked}), 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    enter_good();
    check("good_y_cycles", w_y, 8);
    check("good_y_first", w_first_y, 0);
    check("good_red_cycles", w_red, 0);

    enter_bad();
    repeat (8) tick();
    check("bad_red_cycles", w_red, 4);
    check("bad_red_first", w_first_red, 0);
    check("bad_y_cycles", w_y, 0);
    enter_good();
    check("after_bad_y_cycles", w_y, 8);

    press_last(4'd1);
    repeat (14) tick();
    check("timeout_red_first", w_first_red, 10);
    check("timeout_red_cycles", w_red, 4);

    press_last(4'd1);
    apply('0, 9);
    apply(4'd3, 1);
    apply('0, 1);
    check("terminal_acc_no_red", w_red, 0);
    press(4'd2);
    press_last(4'd4);
    repeat (12) tick();
    check("terminal_acc_opens", w_y, 8);

    press(4'd1);
    apply(4'd3, 5);
    apply('0, 1);
    press(4'd2);
    press_last(4'd4);
    repeat (12) tick();
    check("held_key_opens", w_y, 8);

    apply(4'd1, 2);
    apply('0, 1);
    press(4'd3); press(4'd2); press_last(4'd4);
    repeat (12) tick();
    check("repeat_no_gap_opens", w_y, 8);

    enter_bad(); repeat (6) tick();
    enter_bad(); repeat (6) tick();
    enter_bad();
    repeat (6) tick();
    press(4'd1); press(4'd3); press(4'd2); press(4'd4);
    repeat (30) tick();
    if (LOCK_EN) begin
      check("lock_cycles", w_lock, 32);
      check("lock_first", w_first_lock, 4);
      check("lock_red_cycles", w_red, 36);
      check("lock_ignores_code", w_y, 0);
    end else begin
      check("nolock_locked_cycles", w_lock, 0);
      check("nolock_red_cycles", w_red, 4);
      check("nolock_code_opens", w_y, 8);
    end
    enter_good();
    check("post_lock_opens", w_y, 8);

    press(4'd1); press(4'd3); press(4'd2); press_last(4'd4);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("reset_aborts_open", int'({y, green, red, locked}), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    press(4'd1); press(4'd3);
    #2;
    reset = 1'b0;
    #1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    press(4'd2);
    press_last(4'd4);
    repeat (14) tick();
    check("reset_partial_red_first", w_first_red, 10);
    check("reset_partial_y_cycles", w_y, 0);
    enter_good();
    check("reset_then_good_opens", w_y, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
